// File: rtl/ssm_pkg.sv
// Shared definitions for the multi-channel SSM statistics block.
package ssm_pkg;

  localparam logic [1:0] TAG_HEAD = 2'b01;
  localparam logic [1:0] TAG_BODY = 2'b11;
  localparam logic [1:0] TAG_TAIL = 2'b10;

  localparam int unsigned LEN_HI = 107;
  localparam int unsigned LEN_LO = 96;
  localparam int unsigned CH_HI  = 123;
  localparam int unsigned CH_LO  = 120;

  // Width of the latched payload-bit increment; 4095 bytes * 8 fits in 15 bits.
  localparam int unsigned PB_W   = 16;

  typedef enum logic [1:0] {IDLE = 2'd0, STAT = 2'd1, SKIP = 2'd2} ssm_state_e;

  // Payload bits of a packet, zero for packets shorter than the metadata.
  function automatic logic [PB_W-1:0] payload_bits(input logic [11:0] len,
                                                   input int unsigned meta);
    if (32'(len) < meta) return '0;
    return PB_W'((32'(len) - meta) << 3);
  endfunction

endpackage

// File: rtl/ssm_stat_cnt.sv
// Single statistics counter: synchronous clear, add-by-value, optional saturation.
module ssm_stat_cnt #(
  parameter int unsigned CNT_W    = 64,
  parameter int unsigned INC_W    = 16,
  parameter int unsigned SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [INC_W-1:0] i_inc,
  output logic [CNT_W-1:0] o_q
);

  localparam int unsigned SUM_W = ((CNT_W > INC_W) ? CNT_W : INC_W) + 1;
  localparam logic [SUM_W-1:0] MAX_V = (SUM_W'(1) << CNT_W) - SUM_W'(1);

  logic [CNT_W-1:0] r_q;
  logic [SUM_W-1:0] w_sum;
  logic [CNT_W-1:0] w_nxt;

  // Full-width sum so a carry out of CNT_W is never lost before clamping.
  always_comb begin
    w_sum = SUM_W'(r_q) + SUM_W'(i_inc);
    w_nxt = CNT_W'(w_sum);
    if ((SATURATE != 0) && (w_sum > MAX_V)) w_nxt = '1;
  end

  // Counter register; clear has priority over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_q <= '0;
    else if (i_clr) r_q <= '0;
    else if (i_en)  r_q <= w_nxt;
  end

  assign o_q = r_q;

endmodule

// File: rtl/ssm_stat_mc.sv
// Multi-channel packet/bit statistics snooping the 134-bit SSM packet bus.
module ssm_stat_mc import ssm_pkg::*; #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned CNT_W      = 64,
  parameter int unsigned META_BYTES = 32,
  parameter int unsigned SATURATE   = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      reset_reg,
  input  logic [133:0]              in_ssm_reg_data,
  input  logic                      in_ssm_reg_data_wr,
  input  logic [$clog2(NUM_CH)-1:0] rd_ch_sel,
  output logic [CNT_W-1:0]          out_bit_cnt,
  output logic [CNT_W-1:0]          out_pkt_cnt,
  output logic [CNT_W-1:0]          out_err_cnt,
  output logic [CNT_W-1:0]          ssm_bit_total2lcm,
  output logic [CNT_W-1:0]          ssm_pkt_total2lcm
);

  localparam int unsigned CH_W = $clog2(NUM_CH);
  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_STAT = STAT;
  localparam logic [1:0] ST_SKIP = SKIP;

  logic [1:0]      r_state;
  logic [CH_W-1:0] r_ch;
  logic [PB_W-1:0] r_pb;
  logic            r_runt;

  logic [1:0]      w_tag;
  logic [3:0]      w_id;
  logic [11:0]     w_len;
  logic [CH_W-1:0] w_head_ch;
  logic [CH_W-1:0] w_stray_ch;
  logic [CH_W-1:0] w_rd_idx;
  logic            w_unused_bits;

  logic [1:0]      w_state_nxt;
  logic            w_latch;
  logic            w_commit;
  logic            w_err;
  logic [CH_W-1:0] w_err_ch;

  logic [CNT_W-1:0] w_bit [NUM_CH];
  logic [CNT_W-1:0] w_pkt [NUM_CH];
  logic [CNT_W-1:0] w_errc[NUM_CH];

  assign w_tag = in_ssm_reg_data[133:132];
  assign w_id  = in_ssm_reg_data[CH_HI:CH_LO];
  assign w_len = in_ssm_reg_data[LEN_HI:LEN_LO];
  assign w_unused_bits = ^{in_ssm_reg_data[131:124], in_ssm_reg_data[119:108],
                           in_ssm_reg_data[95:0]};

  // Heads with an out-of-range id fold onto the last channel; stray words onto channel 0.
  assign w_head_ch  = (32'(w_id) >= NUM_CH) ? CH_W'(NUM_CH - 1) : CH_W'(w_id);
  assign w_stray_ch = (32'(w_id) >= NUM_CH) ? '0 : CH_W'(w_id);
  assign w_rd_idx   = (32'(rd_ch_sel) < NUM_CH) ? rd_ch_sel : '0;

  // Next-state and counter control.
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_commit    = 1'b0;
    w_err       = 1'b0;
    w_err_ch    = r_ch;
    if (reset_reg) begin
      // Discard any in-flight packet; keep swallowing it until its tail.
      if (in_ssm_reg_data_wr && (w_tag == TAG_TAIL))      w_state_nxt = ST_IDLE;
      else if (in_ssm_reg_data_wr && (w_tag == TAG_HEAD)) w_state_nxt = ST_SKIP;
      else if (r_state != ST_IDLE)                        w_state_nxt = ST_SKIP;
    end else if (in_ssm_reg_data_wr) begin
      case (r_state)
        ST_IDLE: begin
          if (w_tag == TAG_HEAD) begin
            w_latch     = 1'b1;
            w_state_nxt = ST_STAT;
          end else if ((w_tag == TAG_BODY) || (w_tag == TAG_TAIL)) begin
            w_err    = 1'b1;
            w_err_ch = w_stray_ch;
          end
        end
        ST_STAT: begin
          case (w_tag)
            TAG_BODY: ;
            TAG_TAIL: begin
              if (r_runt) w_err = 1'b1;
              else        w_commit = 1'b1;
              w_state_nxt = ST_IDLE;
            end
            TAG_HEAD: begin
              w_err   = 1'b1;
              w_latch = 1'b1;
            end
            default: begin
              w_err       = 1'b1;
              w_state_nxt = ST_IDLE;
            end
          endcase
        end
        ST_SKIP: begin
          if (w_tag == TAG_TAIL) w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Head latch: channel, payload bit count and runt flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ch   <= '0;
      r_pb   <= '0;
      r_runt <= 1'b0;
    end else if (w_latch) begin
      r_ch   <= w_head_ch;
      r_pb   <= payload_bits(w_len, META_BYTES);
      r_runt <= (32'(w_len) < META_BYTES);
    end
  end

  // Per-channel bit, packet and error counters.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ssm_stat_cnt #(.CNT_W(CNT_W), .INC_W(PB_W), .SATURATE(SATURATE)) u_bit (
      .clk(clk), .rst_n(rst_n), .i_clr(reset_reg),
      .i_en(w_commit && (r_ch == CH_W'(g))), .i_inc(r_pb), .o_q(w_bit[g]));
    ssm_stat_cnt #(.CNT_W(CNT_W), .INC_W(PB_W), .SATURATE(SATURATE)) u_pkt (
      .clk(clk), .rst_n(rst_n), .i_clr(reset_reg),
      .i_en(w_commit && (r_ch == CH_W'(g))), .i_inc(PB_W'(1)), .o_q(w_pkt[g]));
    ssm_stat_cnt #(.CNT_W(CNT_W), .INC_W(PB_W), .SATURATE(SATURATE)) u_err (
      .clk(clk), .rst_n(rst_n), .i_clr(reset_reg),
      .i_en(w_err && (w_err_ch == CH_W'(g))), .i_inc(PB_W'(1)), .o_q(w_errc[g]));
  end

  // Aggregate totals, clamped independently of the channel counters.
  ssm_stat_cnt #(.CNT_W(CNT_W), .INC_W(PB_W), .SATURATE(SATURATE)) u_bit_total (
    .clk(clk), .rst_n(rst_n), .i_clr(reset_reg),
    .i_en(w_commit), .i_inc(r_pb), .o_q(ssm_bit_total2lcm));
  ssm_stat_cnt #(.CNT_W(CNT_W), .INC_W(PB_W), .SATURATE(SATURATE)) u_pkt_total (
    .clk(clk), .rst_n(rst_n), .i_clr(reset_reg),
    .i_en(w_commit), .i_inc(PB_W'(1)), .o_q(ssm_pkt_total2lcm));

  // Registered readout of the selected channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_bit_cnt <= '0;
      out_pkt_cnt <= '0;
      out_err_cnt <= '0;
    end else begin
      out_bit_cnt <= w_bit[w_rd_idx];
      out_pkt_cnt <= w_pkt[w_rd_idx];
      out_err_cnt <= w_errc[w_rd_idx];
    end
  end

endmodule

// File: tb/tb_ssm_stat_mc.sv
// Self-checking bench: three instances (64-bit wrap, 8-bit saturate, 8-bit wrap) share stimulus.
module tb_ssm_stat_mc;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         reset_reg = 1'b0;
  logic [133:0] data = '0;
  logic         wr = 1'b0;
  logic [1:0]   rd_ch_sel = '0;

  logic [63:0] d_bit, d_pkt, d_err, d_tb, d_tp;
  logic [7:0]  s_bit, s_pkt, s_err, s_tb, s_tp;
  logic [7:0]  w_bit, w_pkt, w_err, w_tb, w_tp;

  int nvec = 0;
  int nerr = 0;

  // Reference: exact event counts; narrow variants derived as min(x,255) or x mod 256.
  logic [63:0] m_bit[4], m_pkt[4], m_err[4], m_tb, m_tp;
  bit          m_open, m_skip;
  int          m_och, m_olen;

  always #5 clk = ~clk;

  ssm_stat_mc #(.NUM_CH(4), .CNT_W(64), .META_BYTES(32), .SATURATE(0)) dut (
    .clk(clk), .rst_n(rst_n), .reset_reg(reset_reg), .in_ssm_reg_data(data),
    .in_ssm_reg_data_wr(wr), .rd_ch_sel(rd_ch_sel), .out_bit_cnt(d_bit),
    .out_pkt_cnt(d_pkt), .out_err_cnt(d_err), .ssm_bit_total2lcm(d_tb),
    .ssm_pkt_total2lcm(d_tp));

  ssm_stat_mc #(.NUM_CH(4), .CNT_W(8), .META_BYTES(32), .SATURATE(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .reset_reg(reset_reg), .in_ssm_reg_data(data),
    .in_ssm_reg_data_wr(wr), .rd_ch_sel(rd_ch_sel), .out_bit_cnt(s_bit),
    .out_pkt_cnt(s_pkt), .out_err_cnt(s_err), .ssm_bit_total2lcm(s_tb),
    .ssm_pkt_total2lcm(s_tp));

  ssm_stat_mc #(.NUM_CH(4), .CNT_W(8), .META_BYTES(32), .SATURATE(0)) dut_w (
    .clk(clk), .rst_n(rst_n), .reset_reg(reset_reg), .in_ssm_reg_data(data),
    .in_ssm_reg_data_wr(wr), .rd_ch_sel(rd_ch_sel), .out_bit_cnt(w_bit),
    .out_pkt_cnt(w_pkt), .out_err_cnt(w_err), .ssm_bit_total2lcm(w_tb),
    .ssm_pkt_total2lcm(w_tp));

  function automatic logic [63:0] sat8(input logic [63:0] x);
    return (x > 64'd255) ? 64'd255 : x;
  endfunction

  function automatic logic [63:0] wrap8(input logic [63:0] x);
    return {56'd0, x[7:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Apply one packet rule to the reference counts.
  task automatic m_step(input bit w, input logic [1:0] tag, input int id, input int len,
                        input bit rr);
    if (rr) begin
      for (int c = 0; c < 4; c++) begin m_bit[c] = 0; m_pkt[c] = 0; m_err[c] = 0; end
      m_tb = 0; m_tp = 0;
      if (w && tag == 2'b10)      begin m_open = 0; m_skip = 0; end
      else if (w && tag == 2'b01) begin m_open = 0; m_skip = 1; end
      else if (m_open || m_skip)  begin m_open = 0; m_skip = 1; end
      return;
    end
    if (!w) return;
    if (m_skip) begin
      if (tag == 2'b10) m_skip = 0;
      return;
    end
    if (!m_open) begin
      if (tag == 2'b01) begin
        m_open = 1; m_och = (id >= 4) ? 3 : id; m_olen = len;
      end else if (tag != 2'b00) begin
        m_err[(id >= 4) ? 0 : id] += 1;
      end
      return;
    end
    case (tag)
      2'b01: begin m_err[m_och] += 1; m_och = (id >= 4) ? 3 : id; m_olen = len; end
      2'b10: begin
        if (m_olen < 32) m_err[m_och] += 1;
        else begin
          m_bit[m_och] += 64'((m_olen - 32) * 8);
          m_pkt[m_och] += 1;
          m_tb += 64'((m_olen - 32) * 8);
          m_tp += 1;
        end
        m_open = 0;
      end
      2'b00: begin m_err[m_och] += 1; m_open = 0; end
      default: ;
    endcase
  endtask

  task automatic chk_totals(input string tag);
    chk({tag, "_tb"},   d_tb, m_tb);
    chk({tag, "_tp"},   d_tp, m_tp);
    chk({tag, "_s_tb"}, 64'(s_tb), sat8(m_tb));
    chk({tag, "_s_tp"}, 64'(s_tp), sat8(m_tp));
    chk({tag, "_w_tb"}, 64'(w_tb), wrap8(m_tb));
    chk({tag, "_w_tp"}, 64'(w_tp), wrap8(m_tp));
  endtask

  // Drive one bus cycle, then check totals just after the edge.
  task automatic word(input bit w, input logic [1:0] tag, input int id, input int len,
                      input bit rr);
    @(negedge clk);
    data = '0;
    data[95:0] = {$urandom, $urandom, $urandom};
    data[133:132] = tag;
    data[123:120] = 4'(id);
    data[107:96] = 12'(len);
    wr = w;
    reset_reg = rr;
    @(posedge clk);
    m_step(w, tag, id, len, rr);
    #1;
    chk_totals("tot");
  endtask

  task automatic pkt(input int id, input int len);
    word(1'b1, 2'b01, id, len, 1'b0);
    word(1'b1, 2'b10, id, len, 1'b0);
  endtask

  // Select a channel with an idle cycle so the registered readout settles.
  task automatic read_ch(input int c);
    @(negedge clk);
    wr = 1'b0;
    reset_reg = 1'b0;
    rd_ch_sel = 2'(c);
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    for (int c = 0; c < 4; c++) begin
      read_ch(c);
      chk($sformatf("%s_bit%0d", tag, c), d_bit, m_bit[c]);
      chk($sformatf("%s_pkt%0d", tag, c), d_pkt, m_pkt[c]);
      chk($sformatf("%s_err%0d", tag, c), d_err, m_err[c]);
      chk($sformatf("%s_sbit%0d", tag, c), 64'(s_bit), sat8(m_bit[c]));
      chk($sformatf("%s_spkt%0d", tag, c), 64'(s_pkt), sat8(m_pkt[c]));
      chk($sformatf("%s_serr%0d", tag, c), 64'(s_err), sat8(m_err[c]));
      chk($sformatf("%s_wbit%0d", tag, c), 64'(w_bit), wrap8(m_bit[c]));
      chk($sformatf("%s_wpkt%0d", tag, c), 64'(w_pkt), wrap8(m_pkt[c]));
      chk($sformatf("%s_werr%0d", tag, c), 64'(w_err), wrap8(m_err[c]));
    end
  endtask

  logic [63:0] old_v;

  initial begin
    for (int c = 0; c < 4; c++) begin m_bit[c] = 0; m_pkt[c] = 0; m_err[c] = 0; end
    m_tb = 0; m_tp = 0; m_open = 0; m_skip = 0; m_och = 0; m_olen = 0;

    // Reset values while rst_n is held low.
    #12;
    chk("rst_bit", d_bit, 64'd0);
    chk("rst_pkt", d_pkt, 64'd0);
    chk("rst_err", d_err, 64'd0);
    chk("rst_tb",  d_tb,  64'd0);
    chk("rst_tp",  d_tp,  64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Three-word packet on channel 2.
    word(1'b1, 2'b01, 2, 96, 1'b0);
    word(1'b1, 2'b11, 2, 96, 1'b0);
    word(1'b1, 2'b10, 2, 96, 1'b0);
    read_ch(2);
    chk("p1_bit2", d_bit, 64'd512);
    chk("p1_pkt2", d_pkt, 64'd1);
    chk("p1_err2", d_err, 64'd0);
    chk("p1_tb",   d_tb,  64'd512);
    chk("p1_tp",   d_tp,  64'd1);
    read_ch(0);
    chk("p1_bit0", d_bit, 64'd0);
    chk("p1_pkt0", d_pkt, 64'd0);
    chk("p1_err0", d_err, 64'd0);

    // Head while a packet is open aborts the first one.
    word(1'b1, 2'b01, 1, 64, 1'b0);
    word(1'b1, 2'b01, 1, 40, 1'b0);
    word(1'b1, 2'b11, 1, 40, 1'b0);
    word(1'b1, 2'b10, 1, 40, 1'b0);
    read_ch(1);
    chk("ab_err1", d_err, 64'd1);
    chk("ab_pkt1", d_pkt, 64'd1);
    chk("ab_bit1", d_bit, 64'd64);

    // Runt packet on channel 3 counts as an error only.
    pkt(3, 20);
    read_ch(3);
    chk("runt_err3", d_err, 64'd1);
    chk("runt_pkt3", d_pkt, 64'd0);
    chk("runt_bit3", d_bit, 64'd0);
    chk("runt_tb",   d_tb,  64'd576);
    chk("runt_tp",   d_tp,  64'd2);
    check_all("dir1");

    // Software clear mid-packet; the remainder of that packet is swallowed.
    word(1'b1, 2'b01, 1, 50, 1'b0);
    repeat (3) word(1'b0, 2'b00, 0, 0, 1'b1);
    word(1'b1, 2'b11, 1, 50, 1'b0);
    word(1'b1, 2'b10, 1, 50, 1'b0);
    check_all("clr");
    chk("clr_tb", d_tb, 64'd0);
    pkt(0, 33);
    read_ch(0);
    chk("clr_bit0", d_bit, 64'd8);
    chk("clr_pkt0", d_pkt, 64'd1);

    // Strobe gaps inside a packet, then a stray tail with an out-of-range id.
    word(1'b1, 2'b01, 2, 100, 1'b0);
    word(1'b0, 2'b10, 2, 100, 1'b0);
    word(1'b1, 2'b11, 2, 100, 1'b0);
    word(1'b0, 2'b01, 2, 100, 1'b0);
    word(1'b1, 2'b10, 2, 100, 1'b0);
    word(1'b1, 2'b10, 7, 0, 1'b0);
    read_ch(2);
    chk("gap_bit2", d_bit, 64'd544);
    chk("gap_pkt2", d_pkt, 64'd1);
    chk("gap_err2", d_err, 64'd0);
    read_ch(0);
    chk("stray_err0", d_err, 64'd1);
    check_all("dir2");

    // Commit in the same cycle as a read returns the pre-update value.
    word(1'b1, 2'b01, 0, 40, 1'b0);
    rd_ch_sel = 2'd0;
    old_v = m_pkt[0];
    word(1'b1, 2'b10, 0, 40, 1'b0);
    chk("rd_pre", d_pkt, old_v);
    read_ch(0);
    chk("rd_post", d_pkt, old_v + 64'd1);

    // Saturation versus wrap on the 8-bit instances.
    word(1'b0, 2'b00, 0, 0, 1'b1);
    repeat (40) pkt(0, 33);
    read_ch(0);
    chk("sat_pkt",  64'(s_pkt), 64'd40);
    chk("sat_bit",  64'(s_bit), 64'd255);
    chk("wrap_pkt", 64'(w_pkt), 64'd40);
    chk("wrap_bit", 64'(w_bit), 64'd64);
    chk("full_bit", d_bit, 64'd320);
    chk("sat_tb",   64'(s_tb),  64'd255);
    chk("wrap_tb",  64'(w_tb),  64'd64);

    // Randomized traffic against the reference counts.
    for (int n = 0; n < 600; n++) begin
      int r;
      logic [1:0] tg;
      r = int'($urandom_range(0, 9));
      tg = (r == 0) ? 2'b00 : (r <= 3) ? 2'b01 : (r <= 6) ? 2'b11 : 2'b10;
      word($urandom_range(0, 3) != 0, tg, int'($urandom_range(0, 15)),
           int'($urandom_range(0, 300)), $urandom_range(0, 39) == 0);
      if ((n % 100) == 99) check_all("rnd");
    end
    check_all("end");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/ssm_stat_mc.md
Name: ssm_stat_mc

Overview:
Multi-channel packet/bit statistics block; parametrised successor of the single-counter SSM statistics register. Snoops the 134-bit pkt bus after the SSM and classifies each packet by the input-port field in its metadata head word. Keeps per-channel payload-bit, good-packet and error-packet counters, plus aggregate totals, for readout by the LCM. Commits counts at the tail, not add-then-subtract, and uses full-width arithmetic.

Parameters:
NUM_CH, 4, number of channels; channel id = head word bits [123:120], low $clog2(NUM_CH) bits used, ids >= NUM_CH map to channel NUM_CH-1
CNT_W, 64, width of every counter
META_BYTES, 32, metadata bytes included in the length field and excluded from the bit count
SATURATE, 0, 1 = counters saturate at all-ones; 0 = counters wrap modulo 2^CNT_W

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
reset_reg  in  1  software clear, level-sensitive
in_ssm_reg_data  in  134  pkt word; [133:132] tag: 01 head, 11 middle, 10 tail; head [107:96] = total length in bytes incl. metadata
in_ssm_reg_data_wr  in  1  word strobe
rd_ch_sel  in  $clog2(NUM_CH)  channel to read
out_bit_cnt  out  CNT_W  payload bits of the selected channel
out_pkt_cnt  out  CNT_W  good packets of the selected channel
out_err_cnt  out  CNT_W  error packets of the selected channel
ssm_bit_total2lcm  out  CNT_W  sum of payload bits over all channels
ssm_pkt_total2lcm  out  CNT_W  sum of good packets over all channels

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset value: all counters, outputs, latched length/channel = 0; state = IDLE.
- Head word: at the head (tag 01, wr=1), latch payload_bits = (len - META_BYTES) * 8.
  - Compute in at least 15 bits, zero-extended to CNT_W.
  - If len < META_BYTES, payload_bits = 0 and the runt flag is set.
- Word strobe: cycles with in_ssm_reg_data_wr = 0 are ignored in every state.
- States:
  - IDLE:
    - head -> latch ch/len -> STAT.
    - middle/tail -> err_cnt[ch of word's bits, unknown -> ch 0] +1, stay IDLE.
  - STAT:
    - middle -> stay.
    - tail -> commit -> IDLE.
    - head -> abort current: err_cnt[latched ch] +1; latch new head, stay STAT.
    - tag 00 -> abort current -> IDLE.
  - SKIP: entered when a head arrives while reset_reg = 1. Words are ignored until a tail, then -> IDLE. No counting.
- Commit (tail):
  - Normal: bit_cnt[ch] += payload_bits, pkt_cnt[ch] += 1; totals updated in the same cycle.
  - Runt flag set: err_cnt[ch] += 1 only.
- Counter update: commit and abort take effect at the clock edge of the tail/abort word. Each counter takes at most one update per cycle.
- Overflow: SATURATE=1 clamps at 2^CNT_W-1, with totals clamped independently. SATURATE=0 wraps.
- reset_reg = 1:
  - All counters are forced to 0 every cycle.
  - An in-flight packet is discarded, not counted as an error. State -> IDLE, or SKIP if the current word is a non-tail head.
  - reset_reg falling mid-packet: the remaining words of that packet are ignored (SKIP) until its tail.
- Readout:
  - out_* are registered with 1-cycle latency from rd_ch_sel.
  - A same-cycle commit is visible one cycle later than an unrelated read, i.e. the read returns the pre-update value.
  - Totals are registered and updated at commit.

Decomposition:
- Shared package ssm_pkg: tag constants (HEAD 2'b01, BODY 2'b11, TAIL 2'b10), LEN_HI/LEN_LO = 107/96, CH_HI/CH_LO = 123/120, state enum {IDLE, STAT, SKIP}.
- Sub-module ssm_stat_cnt: one CNT_W counter with clear, increment-by-value, and SATURATE option. Instantiated 3*NUM_CH + 2 times.
- The top level holds the FSM, length latch and read mux.

Test Plan:
- Reset, then a 3-word packet (head len=96, ch 2, body, tail); rd_ch_sel=2 -> bit=512, pkt=1, err=0; totals 512/1; ch0 all 0.
- Head len=64 ch1, then head len=40 ch1, body, tail -> ch1 err=1, pkt=1, bit=64.
- Head len=20 (runt) ch3, tail -> ch3 err=1, pkt=0, bit=0; totals unchanged.
- After counts build up, pulse reset_reg 3 cycles mid-packet (head already seen), deassert, finish the packet with a tail -> all counters 0; next good packet of len=33 on ch0 -> bit=8, pkt=1.
- CNT_W=8, SATURATE=1: 40 packets of len=33 ch0 -> pkt=40, bit=255; SATURATE=0 -> bit=64 (320 mod 256).
- wr=0 gaps between head/body/tail, plus stray tail in IDLE on ch id 7 with NUM_CH=4 -> packet counted normally; stray tail adds err to ch 0 only.
